// File: rtl/bshift.sv
// Registered logical barrel shifter: left and right zero-filled copies of data_in.
// One-cycle latency and one result per cycle; no backpressure, in_valid qualifies each capture.
module bshift #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHIFT_W-1:0] shift_amt,
  output logic [WIDTH-1:0]   l_data_out,
  output logic [WIDTH-1:0]   r_data_out,
  output logic               out_valid
);

  logic [WIDTH-1:0] w_l_shift;
  logic [WIDTH-1:0] w_r_shift;
  logic [WIDTH-1:0] r_l_data;
  logic [WIDTH-1:0] r_r_data;
  logic             r_valid;

  // Stage k moves by 2^k; distances >= WIDTH fall out as zero naturally.
  always_comb begin
    w_l_shift = data_in;
    w_r_shift = data_in;
    for (int k = 0; k < SHIFT_W; k++) begin
      if (shift_amt[k]) begin
        w_l_shift = w_l_shift << (1 << k);
        w_r_shift = w_r_shift >> (1 << k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l_data <= '0;
      r_r_data <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_l_data <= w_l_shift;
        r_r_data <= w_r_shift;
      end
    end
  end

  assign l_data_out = r_l_data;
  assign r_data_out = r_r_data;
  assign out_valid  = r_valid;

endmodule

// File: tb/tb_bshift.sv
// Directed and randomized checks of bshift against a bit-rule reference model.
module tb_bshift;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] data_in;
  logic [3:0]  shift_amt;
  logic [15:0] l_data_out;
  logic [15:0] r_data_out;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_l = '0;
  logic [15:0] exp_r = '0;
  logic        exp_v = 1'b0;

  bshift #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .shift_amt  (shift_amt),
    .l_data_out (l_data_out),
    .r_data_out (r_data_out),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_shl(input logic [15:0] d, input int amt);
    logic [15:0] res;
    res = '0;
    for (int i = 0; i < 16; i++)
      if (i >= amt) res[i] = d[i - amt];
    return res;
  endfunction

  function automatic logic [15:0] model_shr(input logic [15:0] d, input int amt);
    logic [15:0] res;
    res = '0;
    for (int i = 0; i < 16; i++)
      if (i + amt < 16) res[i] = d[i + amt];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_l"}, l_data_out, exp_l);
    chk({tag, "_r"}, r_data_out, exp_r);
    chk({tag, "_v"}, {15'b0, out_valid}, {15'b0, exp_v});
  endtask

  task automatic step(input string tag, input logic v, input logic [15:0] d, input logic [3:0] a);
    in_valid  = v;
    data_in   = d;
    shift_amt = a;
    @(posedge clk);
    #1;
    if (v) begin
      exp_l = model_shl(d, int'(a));
      exp_r = model_shr(d, int'(a));
    end
    exp_v = v;
    chk_model(tag);
  endtask

  initial begin
    // Reset asserted before any clock edge must clear outputs immediately.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    data_in   = 16'hA5C3;
    shift_amt = 4'd3;
    #2;
    chk("rst_l", l_data_out, 16'h0000);
    chk("rst_r", r_data_out, 16'h0000);
    chk("rst_v", {15'b0, out_valid}, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    step("idle0", 1'b0, 16'h1234, 4'd1);
    step("idle1", 1'b0, 16'hFFFF, 4'd7);
    chk("idle_l_zero", l_data_out, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      step("walk", 1'b1, 16'h0001, 4'(i));
      chk("walk_l_const", l_data_out, 16'h0001 << i);
      chk("walk_r_const", r_data_out, (i == 0) ? 16'h0001 : 16'h0000);
    end

    step("mix0", 1'b1, 16'hF00B, 4'd4);
    chk("mix0_l_const", l_data_out, 16'h00B0);
    chk("mix0_r_const", r_data_out, 16'h0F00);
    step("mix1", 1'b1, 16'h00FF, 4'd2);
    chk("mix1_l_const", l_data_out, 16'h03FC);
    chk("mix1_r_const", r_data_out, 16'h003F);

    step("bnd0", 1'b1, 16'h8001, 4'd15);
    chk("bnd0_l_const", l_data_out, 16'h8000);
    chk("bnd0_r_const", r_data_out, 16'h0001);
    step("bnd1", 1'b1, 16'hFFFF, 4'd0);
    chk("bnd1_l_const", l_data_out, 16'hFFFF);
    chk("bnd1_r_const", r_data_out, 16'hFFFF);

    step("hold_seed", 1'b1, 16'h1357, 4'd5);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 16'(($urandom)), 4'($urandom_range(0, 15)));
      chk("hold_l_const", l_data_out, 16'h6AE0);
      chk("hold_r_const", r_data_out, 16'h009A);
    end

    // Reset between edges during a back-to-back valid stream.
    step("ms0", 1'b1, 16'hBEEF, 4'd6);
    in_valid  = 1'b1;
    data_in   = 16'hCAFE;
    shift_amt = 4'd2;
    #3;
    rst_n = 1'b0;
    #1;
    exp_l = '0;
    exp_r = '0;
    exp_v = 1'b0;
    chk_model("ms_rst");
    @(posedge clk);
    #1;
    chk_model("ms_rst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    step("ms1", 1'b1, 16'h1234, 4'd3);
    chk("ms1_l_const", l_data_out, 16'h91A0);
    chk("ms1_r_const", r_data_out, 16'h0246);

    for (int n = 0; n < 300; n++) begin
      step("rnd", ($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
